mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (instr/data) arbiter onto one pipelined memory port.
// Tracks in-order responses with an owner FIFO and guards the instr port against starvation.
module mem_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int OSTD   = 2,
    parameter int STARVE = 4
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            instr_req,
    input  logic            instr_write,
    input  logic [DW/8-1:0] instr_wstrb,
    input  logic [AW-1:0]   instr_addr,
    input  logic [DW-1:0]   instr_wdata,
    output logic            instr_addr_ok,
    output logic            instr_data_ok,
    output logic [DW-1:0]   instr_rdata,

    input  logic            data_req,
    input  logic            data_write,
    input  logic [DW/8-1:0] data_wstrb,
    input  logic [AW-1:0]   data_addr,
    input  logic [DW-1:0]   data_wdata,
    output logic            data_addr_ok,
    output logic            data_data_ok,
    output logic [DW-1:0]   data_rdata,

    output logic            m_req,
    output logic            m_write,
    output logic [DW/8-1:0] m_wstrb,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    input  logic            m_addr_ok,
    input  logic            m_data_ok,
    input  logic [DW-1:0]   m_rdata,

    output logic            err
);

    localparam int PW = (OSTD > 1) ? $clog2(OSTD) : 1;
    localparam int CW = $clog2(OSTD + 1);
    localparam int SW = $clog2(STARVE + 1);

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OSTD-1:0] own_q, own_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            err_q, err_d;

    logic starved;
    logic grant_data;
    logic grant_instr;
    logic not_full;
    logic push;
    logic pop;
    logic head_owner;

    function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
        if (p == PW'(OSTD - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    // Acceptance depends only on registered count, never on m_data_ok.
    always_comb begin
        starved     = (starve_q == SW'(STARVE));
        grant_data  = data_req & ~(instr_req & starved);
        grant_instr = instr_req & ~grant_data;
        not_full    = rst_n & (cnt_q < CW'(OSTD));

        m_req         = (grant_data | grant_instr) & not_full;
        instr_addr_ok = grant_instr & m_addr_ok & not_full;
        data_addr_ok  = grant_data & m_addr_ok & not_full;

        m_write = 1'b0;
        m_wstrb = '0;
        m_addr  = '0;
        m_wdata = '0;
        if (grant_data) begin
            m_write = data_write;
            m_wstrb = data_wstrb;
            m_addr  = data_addr;
            m_wdata = data_wdata;
        end else if (grant_instr) begin
            m_write = instr_write;
            m_wstrb = instr_wstrb;
            m_addr  = instr_addr;
            m_wdata = instr_wdata;
        end
    end

    always_comb begin
        push       = m_req & m_addr_ok;
        pop        = m_data_ok & (cnt_q != '0);
        head_owner = own_q[rd_ptr_q];

        instr_data_ok = pop & ~head_owner;
        data_data_ok  = pop & head_owner;
        instr_rdata   = m_rdata;
        data_rdata    = m_rdata;
        err           = err_q;
    end

    always_comb begin
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        own_d    = own_q;
        starve_d = starve_q;
        err_d    = err_q | (m_data_ok & (cnt_q == '0));

        if (push) begin
            own_d[wr_ptr_q] = grant_data;
            wr_ptr_d        = inc_ptr(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = inc_ptr(rd_ptr_q);
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        if (push & grant_instr) begin
            starve_d = '0;
        end else if (push & grant_data & instr_req & ~starved) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            own_q    <= '0;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            own_q    <= own_d;
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected responses, a monitor pops and compares.
module tb_mem_arbiter;

    localparam logic [31:0] K = 32'hA5A5A5B5;

    typedef struct {
        bit          port;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_req, instr_write, data_req, data_write;
    logic [3:0]  instr_wstrb, data_wstrb, m_wstrb;
    logic [31:0] instr_addr, instr_wdata, data_addr, data_wdata;
    logic        instr_addr_ok, instr_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] instr_rdata, data_rdata;
    logic        m_req, m_write, m_addr_ok, m_data_ok;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        err;

    bit          mem_en;
    bit          stray;
    int          checks;
    int          errors;
    exp_t        expq[$];
    logic [31:0] mq[$];

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .instr_req(instr_req), .instr_write(instr_write), .instr_wstrb(instr_wstrb),
        .instr_addr(instr_addr), .instr_wdata(instr_wdata), .instr_addr_ok(instr_addr_ok),
        .instr_data_ok(instr_data_ok), .instr_rdata(instr_rdata),
        .data_req(data_req), .data_write(data_write), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .m_req(m_req), .m_write(m_write), .m_wstrb(m_wstrb), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: answers each accepted request one cycle later, in order, when enabled.
    initial begin
        m_data_ok = 1'b0;
        m_rdata   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) mq.delete();
            else if (m_req && m_addr_ok) mq.push_back(m_addr ^ K);
            @(posedge clk);
            #1;
            if (!rst_n) begin
                mq.delete();
                m_data_ok = 1'b0;
            end else if (stray) begin
                m_data_ok = 1'b1;
                m_rdata   = '0;
            end else if (mem_en && mq.size() > 0) begin
                m_data_ok = 1'b1;
                m_rdata   = mq.pop_front();
            end else begin
                m_data_ok = 1'b0;
            end
        end
    end

    // Response monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                expq.delete();
            end else if (instr_data_ok || data_data_ok) begin
                if (instr_data_ok && data_data_ok) begin
                    check("both_data_ok", 32'd1, 32'd0);
                end else if (expq.size() == 0) begin
                    check("unexpected_data_ok", 32'd1, 32'd0);
                end else begin
                    e = expq.pop_front();
                    check("resp_port", {31'd0, data_data_ok}, {31'd0, e.port});
                    check("resp_rdata", data_data_ok ? data_rdata : instr_rdata, e.rdata);
                end
            end
        end
    end

    task automatic set_port(input bit port, input bit req, input logic [31:0] addr, input bit wr);
        if (port) begin
            data_req = req; data_addr = addr; data_write = wr;
            data_wstrb = 4'hF; data_wdata = addr + 32'h1000;
        end else begin
            instr_req = req; instr_addr = addr; instr_write = wr;
            instr_wstrb = 4'hF; instr_wdata = addr + 32'h2000;
        end
    endtask

    task automatic do_req(input bit port, input logic [31:0] addr, input bit wr);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        set_port(port, 1'b1, addr, wr);
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (port ? data_addr_ok : instr_addr_ok) begin
                ok = 1'b1;
                expq.push_back('{port, addr ^ K});
            end else begin
                @(posedge clk);
                #1;
            end
        end
        check("req_accept", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
        set_port(port, 1'b0, '0, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain", expq.size(), 32'd0);
    endtask

    initial begin
        string pat;
        logic [1:0] g;
        pat = "DDDDIDDDDI";
        checks = 0; errors = 0;
        mem_en = 1'b1; stray = 1'b0;
        rst_n = 1'b0; m_addr_ok = 1'b1;
        set_port(1'b0, 1'b1, 32'h10, 1'b0);
        set_port(1'b1, 1'b0, '0, 1'b0);

        // Reset state, with instr_req held high
        #3;
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_m_req", {31'd0, m_req}, 32'd0);
        check("rst_instr_addr_ok", {31'd0, instr_addr_ok}, 32'd0);
        check("rst_data_ok", {30'd0, instr_data_ok, data_data_ok}, 32'd0);
        set_port(1'b0, 1'b0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        check("idle_m_addr", m_addr, 32'd0);
        check("idle_m_write", {31'd0, m_write}, 32'd0);

        // Single instr read at 0x10, response 0xA5A5A5A5
        @(posedge clk);
        #1 set_port(1'b0, 1'b1, 32'h10, 1'b0);
        @(negedge clk);
        check("single_instr_addr_ok", {31'd0, instr_addr_ok}, 32'd1);
        check("single_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
        check("single_m_addr", m_addr, 32'h10);
        expq.push_back('{1'b0, 32'hA5A5A5A5});
        @(posedge clk);
        #1 set_port(1'b0, 1'b0, '0, 1'b0);
        drain();

        // Both ports requesting continuously
        @(posedge clk);
        #1;
        set_port(1'b0, 1'b1, 32'h100, 1'b0);
        set_port(1'b1, 1'b1, 32'h200, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            g = {instr_addr_ok, data_addr_ok};
            check($sformatf("grant_%0d", i), {30'd0, g}, (pat[i] == "D") ? 32'd1 : 32'd2);
            if (g == 2'b01) expq.push_back('{1'b1, 32'h200 ^ K});
            if (g == 2'b10) expq.push_back('{1'b0, 32'h100 ^ K});
        end
        @(posedge clk);
        #1;
        set_port(1'b0, 1'b0, '0, 1'b0);
        set_port(1'b1, 1'b0, '0, 1'b0);
        drain();

        // Outstanding limit: third request blocked until after the first pop
        @(negedge clk) mem_en = 1'b0;
        do_req(1'b1, 32'h400, 1'b0);
        do_req(1'b1, 32'h404, 1'b0);
        @(posedge clk);
        #1 set_port(1'b1, 1'b1, 32'h408, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_addr_ok", {31'd0, data_addr_ok}, 32'd0);
            check("full_m_req", {31'd0, m_req}, 32'd0);
        end
        mem_en = 1'b1;
        @(negedge clk);
        check("full_pop_cycle_addr_ok", {31'd0, data_addr_ok}, 32'd0);
        @(negedge clk);
        check("after_pop_addr_ok", {31'd0, data_addr_ok}, 32'd1);
        if (data_addr_ok) expq.push_back('{1'b1, 32'h408 ^ K});
        @(posedge clk);
        #1 set_port(1'b1, 1'b0, '0, 1'b0);
        drain();

        // Back-to-back I, D(write), I with responses overlapping acceptances
        @(posedge clk);
        #1 set_port(1'b0, 1'b1, 32'h300, 1'b0);
        @(negedge clk);
        check("ilv_i1", {31'd0, instr_addr_ok}, 32'd1);
        expq.push_back('{1'b0, 32'h300 ^ K});
        @(posedge clk);
        #1;
        set_port(1'b0, 1'b0, '0, 1'b0);
        set_port(1'b1, 1'b1, 32'h304, 1'b1);
        data_wstrb = 4'h3; data_wdata = 32'hDEADBEEF;
        @(negedge clk);
        check("ilv_d1", {31'd0, data_addr_ok}, 32'd1);
        check("ilv_m_write", {31'd0, m_write}, 32'd1);
        check("ilv_m_wstrb", {28'd0, m_wstrb}, 32'h3);
        check("ilv_m_wdata", m_wdata, 32'hDEADBEEF);
        expq.push_back('{1'b1, 32'h304 ^ K});
        @(posedge clk);
        #1;
        set_port(1'b1, 1'b0, '0, 1'b0);
        set_port(1'b0, 1'b1, 32'h308, 1'b0);
        @(negedge clk);
        check("ilv_i2", {31'd0, instr_addr_ok}, 32'd1);
        expq.push_back('{1'b0, 32'h308 ^ K});
        @(posedge clk);
        #1 set_port(1'b0, 1'b0, '0, 1'b0);
        drain();

        // Stray response with nothing outstanding
        @(negedge clk);
        check("err_before", {31'd0, err}, 32'd0);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        check("err_same_cycle", {31'd0, err}, 32'd0);
        @(negedge clk);
        check("err_set", {31'd0, err}, 32'd1);
        repeat (4) @(negedge clk);
        check("err_sticky", {31'd0, err}, 32'd1);

        // Reset with two outstanding
        mem_en = 1'b0;
        do_req(1'b0, 32'h500, 1'b0);
        do_req(1'b1, 32'h504, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_err", {31'd0, err}, 32'd0);
        check("rst_mid_data_ok", {30'd0, instr_data_ok, data_data_ok}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mem_en = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_err", {31'd0, err}, 32'd0);
        mem_en = 1'b0;
        do_req(1'b0, 32'h600, 1'b0);
        do_req(1'b1, 32'h604, 1'b0);
        @(posedge clk);
        #1 set_port(1'b0, 1'b1, 32'h608, 1'b0);
        @(negedge clk);
        check("post_rst_full", {31'd0, instr_addr_ok}, 32'd0);
        @(posedge clk);
        #1 set_port(1'b0, 1'b0, '0, 1'b0);
        @(negedge clk) mem_en = 1'b1;
        drain();
        repeat (3) @(negedge clk);
        check("final_err", {31'd0, err}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
